// File: rtl/instruction_loader_if.sv
// Bus bundle between the instruction loader and its environment: the UART byte
// stream and load request going in, the instruction-memory write port and
// session status coming out.
interface instruction_loader_if #(
  parameter int NB_BYTE = 8,
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               i_load_en;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_wr_en;
  logic [NB_ADDR-1:0] o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;

  // Environment side: supplies bytes and load requests, observes writes.
  modport master (
    output i_load_en, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count
  );

  // Loader side.
  modport slave (
    input  i_load_en, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: packs a UART byte stream big-endian into instruction
// words and writes them to consecutive instruction-memory addresses until the
// halt word is written or the memory is full. All outputs are registered.
module instruction_loader #(
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic                  clk,
  input logic                  i_rst,
  instruction_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NB_DATA-1:0] wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [NB_ADDR:0]   word_count_q, word_count_d;
  logic [NB_DATA-1:0] shifted_word;

  assign shifted_word = {word_q[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they appear registered together with the state they belong to.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.i_load_en) begin
          state_d      = ASSEMBLE;
          byte_cnt_d   = 2'd0;
          word_d       = '0;
          addr_d       = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end

      ASSEMBLE: begin
        busy_d = 1'b1;
        if (bus.i_rx_valid) begin
          word_d     = shifted_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shifted_word;
          end
        end
      end

      WRITE: begin
        word_count_d = word_count_q + 1'b1;
        if (wr_data_q == HALT_WORD) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (addr_q == ADDR_MAX) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          overflow_d = 1'b1;
        end else begin
          state_d = ASSEMBLE;
          addr_d  = addr_q + 1'b1;
          busy_d  = 1'b1;
          // A byte arriving while the write is in flight opens the next word.
          if (bus.i_rx_valid) begin
            word_d     = shifted_word;
            byte_cnt_d = 2'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_q       <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_word_count = word_count_q;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8, meaning width of one received byte.
REQ-002 SHALL have parameter NB_DATA, default 32, meaning instruction word width, equal to 4*NB_BYTE.
REQ-003 SHALL have parameter NB_ADDR, default 8, meaning instruction-memory word-address width (256 words).
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the end-of-program marker.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_load_en  input  1  request to start a load session, sampled in IDLE only.
REQ-008 SHALL have port i_rx_data  input  NB_BYTE  received byte from the UART receiver.
REQ-009 SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-010 SHALL have port o_wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port o_wr_addr  output  NB_ADDR  word address of the current write.
REQ-012 SHALL have port o_wr_data  output  NB_DATA  assembled instruction word.
REQ-013 SHALL have port o_busy  output  1  high while a session is active (ASSEMBLE, WRITE).
REQ-014 SHALL have port o_done  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port o_overflow  output  1  sticky flag: memory filled before HALT_WORD was received.
REQ-016 SHALL have port o_word_count  output  NB_ADDR+1  number of words written in the current or last session.

Function
REQ-017 SHALL implement a state machine with states IDLE, ASSEMBLE, WRITE, DONE; all outputs registered.
REQ-018 IDLE: i_rx_valid ignored; on i_load_en=1 go to ASSEMBLE, clearing address, byte counter, o_word_count and o_overflow.
REQ-019 ASSEMBLE: each i_rx_valid=1 shifts i_rx_data into the word big-endian (first byte -> bits [31:24]) and increments a 2-bit byte counter.
REQ-020 On acceptance of the 4th byte, SHALL go to WRITE; o_wr_en=1 in the following cycle, so latency is 1 cycle from the 4th strobe.
REQ-021 WRITE (exactly one cycle): o_wr_en=1, o_wr_addr=current address, o_wr_data=assembled word; then address +1 and o_word_count +1.
REQ-022 A HALT_WORD SHALL still be written to memory, after which the state SHALL go to DONE.
REQ-023 If the written word is not HALT_WORD and the address was 2^NB_ADDR-1, SHALL set o_overflow=1 and go to DONE; no address wrap-around.
REQ-024 Otherwise WRITE SHALL return to ASSEMBLE.
REQ-025 An i_rx_valid arriving in the WRITE cycle SHALL be captured as byte 0 of the next word; no byte is lost.
REQ-026 DONE: o_done=1 for exactly one cycle, o_busy=0, then go to IDLE; bytes arriving in DONE are ignored.
REQ-027 i_load_en while o_busy=1 SHALL be ignored.
REQ-028 o_wr_en SHALL be 0 in every state except WRITE; o_wr_addr and o_wr_data hold their last values otherwise.
REQ-029 o_word_count and o_overflow SHALL hold after DONE until the next session starts.

Reset
REQ-030 i_rst=1 at a clock edge SHALL force IDLE and set o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count and the byte counter to 0.
REQ-031 Reset mid-session SHALL discard any partial word, perform no further writes, and produce no o_done pulse.
REQ-032 Reset SHALL take priority over i_load_en and i_rx_valid in the same cycle.

Verification
REQ-033 Send i_load_en, then bytes 20,08,00,05 / FF,FF,FF,FF -> writes 0x20080005@0 and 0xFFFFFFFF@1, o_done pulse, o_word_count=2, o_overflow=0.
REQ-034 Check timing: o_wr_en high exactly one cycle after the 4th i_rx_valid; with a byte strobed in the WRITE cycle, the next word starts with that byte.
REQ-035 Send 256 non-halt words -> 256 writes to addresses 0..255, o_overflow=1, o_done pulse, o_word_count=256, no write to address 0 after 255.
REQ-036 Assert i_rst after 2 bytes of a word -> no write, outputs zero; a new session then writes its first word at address 0.
REQ-037 Send bytes in IDLE, and i_load_en during ASSEMBLE -> no writes and no restart; the session proceeds unchanged.
